// File: rtl/flag_status_register.sv
// Captures ALU result/flags, accumulates sticky flags and saturating event
// counters, evaluates condition codes and serves counter snapshots by handshake.
module flag_status_register (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] resultado,
    input  logic [2:0] flags_in,
    input  logic [2:0] operacao,
    input  logic       clear_sticky,
    input  logic [2:0] cond_sel,
    input  logic       rd_req,
    input  logic [1:0] rd_sel,
    output logic       in_ready,
    output logic [7:0] res_q,
    output logic [2:0] flags_q,
    output logic [2:0] sticky_q,
    output logic       cond_true,
    output logic       rd_valid,
    output logic [7:0] rd_data
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam logic [2:0]  OP_ADD = 3'b100;
    localparam logic [2:0]  OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        READ   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   capture;
    logic   update;
    logic   load_rd;

    logic [FLAG_W-1:0] flags_masked;
    logic [CNT_W-1:0]  cnt_z;
    logic [CNT_W-1:0]  cnt_c;
    logic [CNT_W-1:0]  cnt_v;
    logic [CNT_W-1:0]  cnt_op;
    logic [CNT_W-1:0]  cnt_sel;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture has priority over a pending readback request in IDLE
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        update     = 1'b0;
        load_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    capture    = 1'b1;
                    next_state = UPDATE;
                end else if (rd_req) begin
                    load_rd    = 1'b1;
                    next_state = READ;
                end
            end
            UPDATE: begin
                update     = 1'b1;
                next_state = IDLE;
            end
            READ: begin
                if (!rd_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // Only ADD/SUB produce meaningful V and C; Zero always passes through
    assign flags_masked = ((operacao == OP_ADD) || (operacao == OP_SUB)) ?
                          flags_in : {2'b00, flags_in[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (capture) begin
            res_q   <= DATA_W'(resultado);
            flags_q <= flags_masked;
        end
    end

    // Clear wins over a same-cycle UPDATE increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
            cnt_z    <= '0;
            cnt_c    <= '0;
            cnt_v    <= '0;
            cnt_op   <= '0;
        end else if (clear_sticky) begin
            sticky_q <= '0;
            cnt_z    <= '0;
            cnt_c    <= '0;
            cnt_v    <= '0;
            cnt_op   <= '0;
        end else if (update) begin
            sticky_q <= sticky_q | flags_q;
            cnt_z    <= sat_inc(cnt_z, flags_q[0]);
            cnt_c    <= sat_inc(cnt_c, flags_q[1]);
            cnt_v    <= sat_inc(cnt_v, flags_q[2]);
            cnt_op   <= sat_inc(cnt_op, 1'b1);
        end
    end

    always_comb begin
        cnt_sel = cnt_z;
        case (rd_sel)
            2'b00:   cnt_sel = cnt_z;
            2'b01:   cnt_sel = cnt_c;
            2'b10:   cnt_sel = cnt_v;
            2'b11:   cnt_sel = cnt_op;
            default: cnt_sel = cnt_z;
        endcase
    end

    // Snapshot taken on entry to READ so later clears cannot disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (load_rd) begin
                rd_data <= cnt_sel;
            end
            rd_valid <= (next_state == READ);
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[0];
            3'b010:  cond_true = ~flags_q[0];
            3'b011:  cond_true = flags_q[1];
            3'b100:  cond_true = ~flags_q[1];
            3'b101:  cond_true = flags_q[2];
            3'b110:  cond_true = ~flags_q[2];
            3'b111:  cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_status_register.sv
// Directed bench for flag_status_register with a scoreboard of expected
// captures and readbacks kept against an independent behavioural model.
module tb_flag_status_register;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] resultado;
    logic [2:0] flags_in;
    logic [2:0] operacao;
    logic       clear_sticky;
    logic [2:0] cond_sel;
    logic       rd_req;
    logic [1:0] rd_sel;
    logic       in_ready;
    logic [7:0] res_q;
    logic [2:0] flags_q;
    logic [2:0] sticky_q;
    logic       cond_true;
    logic       rd_valid;
    logic [7:0] rd_data;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] cap_q[$];
    logic [7:0]  rd_q[$];

    // Model state: counters indexed 0=Z, 1=C, 2=V, 3=ops
    logic [7:0] m_cnt[4];
    logic [2:0] m_sticky;
    logic [2:0] m_flags;

    flag_status_register dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .resultado    (resultado),
        .flags_in     (flags_in),
        .operacao     (operacao),
        .clear_sticky (clear_sticky),
        .cond_sel     (cond_sel),
        .rd_req       (rd_req),
        .rd_sel       (rd_sel),
        .in_ready     (in_ready),
        .res_q        (res_q),
        .flags_q      (flags_q),
        .sticky_q     (sticky_q),
        .cond_true    (cond_true),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_inc(input logic [7:0] v, input logic en);
        if (!en || v == 8'd255) return v;
        return v + 8'd1;
    endfunction

    task automatic model_clear();
        m_sticky = 3'b000;
        for (int k = 0; k < 4; k++) m_cnt[k] = 8'd0;
    endtask

    task automatic model_update(input logic [2:0] f);
        m_sticky = m_sticky | f;
        m_cnt[0] = m_inc(m_cnt[0], f[0]);
        m_cnt[1] = m_inc(m_cnt[1], f[1]);
        m_cnt[2] = m_inc(m_cnt[2], f[2]);
        m_cnt[3] = m_inc(m_cnt[3], 1'b1);
    endtask

    function automatic logic [2:0] mask_flags(input logic [2:0] f, input logic [2:0] op);
        if (op == 3'b100 || op == 3'b101) return f;
        return {2'b00, f[0]};
    endfunction

    function automatic logic cond_model(input logic [2:0] sel, input logic [2:0] f);
        case (sel)
            3'd0: return 1'b1;
            3'd1: return f[0];
            3'd2: return !f[0];
            3'd3: return f[1];
            3'd4: return !f[1];
            3'd5: return f[2];
            3'd6: return !f[2];
            default: return 1'b0;
        endcase
    endfunction

    // One capture; optionally clears during the UPDATE cycle
    task automatic capture(input logic [7:0] r, input logic [2:0] f, input logic [2:0] op,
                           input bit clr_in_update);
        logic [2:0]  mf;
        logic [10:0] e;
        check("in_ready_idle", 32'(in_ready), 32'(1));
        mf = mask_flags(f, op);
        cap_q.push_back({r, mf});
        resultado = r;
        flags_in  = f;
        operacao  = op;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = cap_q.pop_front();
        check("res_q", 32'(res_q), 32'(e[10:3]));
        check("flags_q", 32'(flags_q), 32'(e[2:0]));
        check("in_ready_update", 32'(in_ready), 32'(0));
        m_flags = mf;
        if (clr_in_update) clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        if (clr_in_update) model_clear();
        else model_update(mf);
        check("sticky_q", 32'(sticky_q), 32'(m_sticky));
        check("in_ready_back", 32'(in_ready), 32'(1));
    endtask

    task automatic readback(input logic [1:0] sel);
        int n;
        logic [7:0] e;
        rd_q.push_back(m_cnt[sel]);
        rd_sel = sel;
        rd_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rd_valid && n < 8);
        check("rd_valid_rise", 32'(rd_valid), 32'(1));
        e = rd_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e));
        check("in_ready_read", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        check("rd_valid_hold", 32'(rd_valid), 32'(1));
        check("rd_data_hold", 32'(rd_data), 32'(e));
        rd_req = 1'b0;
        @(posedge clk); #1;
        check("rd_valid_fall", 32'(rd_valid), 32'(0));
        check("rd_data_keep", 32'(rd_data), 32'(e));
        check("in_ready_after_read", 32'(in_ready), 32'(1));
    endtask

    task automatic do_clear();
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        model_clear();
        check("clear_sticky_q", 32'(sticky_q), 32'(0));
        check("clear_in_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic cond_sweep();
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            check("cond_true", 32'(cond_true), 32'(cond_model(3'(s), m_flags)));
        end
    endtask

    initial begin
        logic [7:0] e;
        rst_n = 1'b0; in_valid = 1'b0; resultado = '0; flags_in = '0; operacao = '0;
        clear_sticky = 1'b0; cond_sel = '0; rd_req = 1'b0; rd_sel = '0;
        model_clear();
        m_flags = 3'b000;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_res_q", 32'(res_q), 32'(0));
        check("rst_flags_q", 32'(flags_q), 32'(0));
        check("rst_sticky_q", 32'(sticky_q), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        cond_sweep();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD capture
        capture(8'h00, 3'b011, 3'b100, 1'b0);
        check("add_sticky", 32'(sticky_q), 32'(3'b011));
        for (int s = 0; s < 4; s++) readback(2'(s));
        cond_sweep();

        // Masking of V/C for non-arithmetic ops
        capture(8'h33, 3'b111, 3'b010, 1'b0);
        check("mask_flags_q", 32'(flags_q), 32'(3'b001));
        cond_sweep();
        capture(8'hC4, 3'b110, 3'b101, 1'b0);
        cond_sweep();

        // Saturation
        do_clear();
        for (int i = 0; i < 300; i++) capture(8'(i), 3'b001, 3'b000, 1'b0);
        readback(2'b00);
        readback(2'b11);
        readback(2'b01);

        // Simultaneous capture and readback request
        do_clear();
        resultado = 8'h5A; flags_in = 3'b110; operacao = 3'b101;
        in_valid = 1'b1; rd_sel = 2'b10; rd_req = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sim_res_q", 32'(res_q), 32'(8'h5A));
        check("sim_flags_q", 32'(flags_q), 32'(3'b110));
        check("sim_rd_valid_e1", 32'(rd_valid), 32'(0));
        m_flags = 3'b110;
        model_update(3'b110);
        rd_q.push_back(m_cnt[2]);
        @(posedge clk); #1;
        check("sim_rd_valid_e2", 32'(rd_valid), 32'(0));
        @(posedge clk); #1;
        check("sim_rd_valid_e3", 32'(rd_valid), 32'(1));
        e = rd_q.pop_front();
        check("sim_rd_data", 32'(rd_data), 32'(e));
        rd_req = 1'b0;
        @(posedge clk); #1;
        check("sim_rd_valid_fall", 32'(rd_valid), 32'(0));

        // Clear during UPDATE beats the increment
        capture(8'h01, 3'b111, 3'b100, 1'b1);
        check("clr_upd_sticky", 32'(sticky_q), 32'(0));
        check("clr_upd_res_q", 32'(res_q), 32'(8'h01));
        readback(2'b11);
        readback(2'b00);

        // Readback hold across a clear
        for (int i = 0; i < 5; i++) capture(8'(i + 16), 3'b000, 3'b000, 1'b0);
        rd_sel = 2'b11; rd_req = 1'b1;
        @(posedge clk); #1;
        check("hold_rd_valid", 32'(rd_valid), 32'(1));
        check("hold_rd_data", 32'(rd_data), 32'(5));
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        model_clear();
        check("hold_after_clr_data", 32'(rd_data), 32'(5));
        check("hold_after_clr_valid", 32'(rd_valid), 32'(1));
        rd_req = 1'b0;
        @(posedge clk); #1;
        check("hold_fall_valid", 32'(rd_valid), 32'(0));
        check("hold_fall_data", 32'(rd_data), 32'(5));
        readback(2'b11);

        // Reset mid-READ, observed before any clock edge
        capture(8'hA5, 3'b011, 3'b100, 1'b0);
        rd_sel = 2'b00; rd_req = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_rd_valid", 32'(rd_valid), 32'(1));
        rst_n = 1'b0;
        #2;
        model_clear();
        m_flags = 3'b000;
        check("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
        check("mid_rst_rd_data", 32'(rd_data), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(1));
        check("mid_rst_sticky", 32'(sticky_q), 32'(0));
        check("mid_rst_res_q", 32'(res_q), 32'(0));
        check("mid_rst_flags_q", 32'(flags_q), 32'(0));
        rd_req = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        for (int s = 0; s < 4; s++) readback(2'(s));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/flag_status_register.md
FLAG_STATUS_REGISTER -- requirements
Module: flag_status_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The ports are:
- clk, input, 1 bit: the single clock; all state updates on its rising edge.
- rst_n, input, 1 bit: asynchronous, active-low reset.
- in_valid, input, 1 bit: ALU result and flags are presented.
- resultado, input, 8 bits: ALU result.
- flags_in, input, 3 bits: {Overflow, Carry, Zero} from the flag generator.
- operacao, input, 3 bits: ALU opcode (100 = ADD, 101 = SUB).
- clear_sticky, input, 1 bit: synchronous clear of sticky flags and counters.
- cond_sel, input, 3 bits: condition code select.
- rd_req, input, 1 bit: counter readback request, 4-phase handshake.
- rd_sel, input, 2 bits: counter select.
- in_ready, output, 1 bit: block accepts a capture this cycle.
- res_q, output, 8 bits: last captured result.
- flags_q, output, 3 bits: last captured {V,C,Z} after masking.
- sticky_q, output, 3 bits: OR of every captured flags_q since the last clear.
- cond_true, output, 1 bit: evaluated condition.
- rd_valid, output, 1 bit: rd_data is valid.
- rd_data, output, 8 bits: selected counter snapshot.

Function
REQ-002 The control state machine SHALL have three states: IDLE, UPDATE and READ.
REQ-003 in_ready SHALL be 1 only in IDLE and SHALL be decoded from state alone.
REQ-004 In IDLE, in_valid=1 SHALL cause a capture at the clock edge and a transition to UPDATE.
- res_q <= resultado.
- flags_q <= masked flags_in.
REQ-005 Masking: when operacao is neither 100 nor 101, flags_q[2:1] SHALL be stored as 0; flags_q[0] (Zero) SHALL always be stored unmasked.
REQ-006 In IDLE, if in_valid and rd_req are both 1, the capture SHALL win; rd_req SHALL be serviced on a later IDLE cycle.
REQ-007 UPDATE SHALL last exactly one cycle, then return to IDLE. At the UPDATE edge:
- sticky_q <= sticky_q | flags_q.
- cnt_z, cnt_c and cnt_v (8 bits each) SHALL each increment when the corresponding flags_q bit is 1.
- cnt_op (8 bits) SHALL always increment.
REQ-008 All counters SHALL saturate at 255 and SHALL never wrap to 0.
REQ-009 The capture-to-updated-counters latency SHALL be 2 clock edges. in_valid SHALL be ignored while not in IDLE.
REQ-010 In IDLE with rd_req=1 and in_valid=0, the block SHALL go to READ. At that edge, rd_data SHALL be loaded with the counter selected by rd_sel:
- 00: cnt_z.
- 01: cnt_c.
- 10: cnt_v.
- 11: cnt_op.
REQ-011 In READ, rd_valid SHALL be 1 and rd_data SHALL be held stable, including if the counters are cleared.
REQ-012 In READ, when rd_req=0 the block SHALL return to IDLE at the next edge, with rd_valid=0 from that edge onward. rd_data SHALL retain its last value.
REQ-013 clear_sticky=1 SHALL, at the next edge and in any state, zero sticky_q and all four counters.
REQ-014 clear_sticky SHALL take priority over a simultaneous UPDATE increment.
REQ-015 clear_sticky SHALL NOT alter the state machine, res_q, flags_q or rd_data.
REQ-016 cond_true SHALL be combinational from flags_q and cond_sel:
- 000: 1.
- 001: Z.
- 010: !Z.
- 011: C.
- 100: !C.
- 101: V.
- 110: !V.
- 111: 0.

Reset
REQ-017 While rst_n=0, the block SHALL immediately, without waiting for a clock edge:
- enter IDLE;
- clear res_q, flags_q, sticky_q, rd_data, rd_valid and all counters to 0.
REQ-018 During reset, in_ready SHALL be 1 and cond_true SHALL follow REQ-016 with flags_q=0.
REQ-019 Reset asserted mid-UPDATE or mid-READ SHALL abort the operation with no partial counter increment.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD capture: resultado=8'h00, flags_in=3'b011, operacao=100, in_valid for 1 cycle -> next edge res_q=00, flags_q=011, in_ready=0; following edge sticky_q=011, cnt_z=1, cnt_c=1, cnt_v=0, cnt_op=1, in_ready=1.
- Masking: operacao=010, flags_in=3'b111 -> flags_q=001; cond_sel=011 gives cond_true=0; cond_sel=001 gives cond_true=1.
- Saturation: 300 captures with flags_in=001, op=000 -> cnt_z=255 and cnt_op=255; readback with rd_sel=00 gives rd_data=255, rd_valid=1 until rd_req drops, then 0 one edge later.
- Simultaneous events: in_valid=1 and rd_req=1 in IDLE -> capture first, rd_valid asserts 2 edges later; clear_sticky during UPDATE -> counters 0, sticky_q=000.
- Readback hold: enter READ with cnt_op=5, then pulse clear_sticky -> rd_data stays 5 while rd_valid=1.
- Reset mid-READ: rst_n=0 -> rd_valid=0, rd_data=0 and counters 0 without a clock edge; in_ready=1.
